// File: rtl/io_port_controller_pkg.sv
// Shared defaults for the Mini-SRC buffered I/O port (the io_defs constants).
// Also holds the FIFO occupancy-counter sizing helper.
package io_port_controller_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH      = 4;

   // An occupancy counter must hold 0..DEPTH inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/io_port_controller_if.sv
// Processor in/out-port strobes and host valid/ready streams of the I/O port.
// The slave modport is the controller view; master is the processor+host view.
interface io_port_controller_if
   import io_port_controller_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  in_outport_write;
   logic [DATA_WIDTH-1:0] in_outport_data;
   logic                  in_inport_read;
   logic [DATA_WIDTH-1:0] out_inport_data;
   logic [DATA_WIDTH-1:0] out_outport;
   logic                  out_in_empty;
   logic                  out_out_full;
   logic                  out_overflow;
   logic                  out_underflow;
   logic                  in_clear_flags;
   logic                  host_tx_valid;
   logic                  host_tx_ready;
   logic [DATA_WIDTH-1:0] host_tx_data;
   logic                  host_rx_valid;
   logic                  host_rx_ready;
   logic [DATA_WIDTH-1:0] host_rx_data;

   modport slave (
      input  in_outport_write, in_outport_data, in_inport_read, in_clear_flags,
      input  host_tx_ready, host_rx_valid, host_rx_data,
      output out_inport_data, out_outport, out_in_empty, out_out_full,
      output out_overflow, out_underflow, host_tx_valid, host_tx_data, host_rx_ready
   );

   modport master (
      output in_outport_write, in_outport_data, in_inport_read, in_clear_flags,
      output host_tx_ready, host_rx_valid, host_rx_data,
      input  out_inport_data, out_outport, out_in_empty, out_out_full,
      input  out_overflow, out_underflow, host_tx_valid, host_tx_data, host_rx_ready
   );

endinterface

// File: rtl/io_port_controller_sync_fifo.sv
// Show-ahead synchronous FIFO; rdata is the head word, forced to 0 while empty.
// Push while full is honoured only when a pop happens in the same cycle.
module sync_fifo
   import io_port_controller_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              wdata,
   output logic [WIDTH-1:0]              rdata,
   output logic                          empty,
   output logic                          full,
   output logic [count_width(DEPTH)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/io_port_controller.sv
// Buffered Mini-SRC I/O port: out-FIFO toward the host, in-FIFO toward the processor,
// a display mirror of the last out-port write, and sticky overflow/underflow flags.
module io_port_controller
   import io_port_controller_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   io_port_controller_if.slave   bus
);
   localparam int CW = count_width(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic          out_empty;
   logic          out_full;
   logic [CW-1:0] out_count;
   logic          in_empty;
   logic          in_full;
   logic [CW-1:0] in_count;
   logic          tx_pop;
   logic          out_push;
   logic          write_drop;
   logic          rx_push;
   logic          in_pop;
   logic          read_empty;
   logic          unused_status;

   // Handshakes only depend on registered FIFO state, never on strobes.
   assign bus.host_tx_valid = !out_empty;
   assign bus.host_rx_ready = (in_count != FULL_CNT);
   assign bus.out_in_empty  = in_empty;
   assign bus.out_out_full  = out_full;

   assign tx_pop     = bus.host_tx_valid && bus.host_tx_ready;
   assign out_push   = bus.in_outport_write && (!out_full || tx_pop);
   assign write_drop = bus.in_outport_write && out_full && !tx_pop;
   assign rx_push    = bus.host_rx_valid && bus.host_rx_ready;
   assign in_pop     = bus.in_inport_read && !in_empty;
   assign read_empty = bus.in_inport_read && in_empty;

   assign unused_status = &{1'b0, in_full, out_count};

   sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_out_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (out_push),
      .pop   (tx_pop),
      .wdata (bus.in_outport_data),
      .rdata (bus.host_tx_data),
      .empty (out_empty),
      .full  (out_full),
      .count (out_count)
   );

   sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_in_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .pop   (in_pop),
      .wdata (bus.host_rx_data),
      .rdata (bus.out_inport_data),
      .empty (in_empty),
      .full  (in_full),
      .count (in_count)
   );

   // The mirror follows every write, including ones the FIFO drops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.out_outport <= '0;
      end else if (bus.in_outport_write) begin
         bus.out_outport <= bus.in_outport_data;
      end
   end

   // Clear wins over a set arriving in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.out_overflow  <= 1'b0;
         bus.out_underflow <= 1'b0;
      end else if (bus.in_clear_flags) begin
         bus.out_overflow  <= 1'b0;
         bus.out_underflow <= 1'b0;
      end else begin
         bus.out_overflow  <= bus.out_overflow  | write_drop;
         bus.out_underflow <= bus.out_underflow | read_empty;
      end
   end

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: out path, host rx path, flags and async reset.
module tb_io_port_controller;

   logic clk;
   logic reset;
   int   total;
   int   passed;

   io_port_controller_if #(.DATA_WIDTH(32)) bus ();

   io_port_controller #(.DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
      else passed++;
   endtask

   task automatic test_reset();
      reset                = 1'b0;
      bus.in_outport_write = 1'b0;
      bus.in_outport_data  = '0;
      bus.in_inport_read   = 1'b0;
      bus.in_clear_flags   = 1'b0;
      bus.host_tx_ready    = 1'b0;
      bus.host_rx_valid    = 1'b0;
      bus.host_rx_data     = '0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      total++; if (bus.out_in_empty !== 1'b1) $display("FAIL rst_in_empty: got %b expected 1", bus.out_in_empty); else passed++;
      total++; if (bus.host_rx_ready !== 1'b1) $display("FAIL rst_rx_ready: got %b expected 1", bus.host_rx_ready); else passed++;
      total++; if (bus.host_tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b expected 0", bus.host_tx_valid); else passed++;
      total++; if (bus.out_outport !== 32'h0) $display("FAIL rst_outport: got %h expected 0", bus.out_outport); else passed++;
      total++; if (bus.out_out_full !== 1'b0) $display("FAIL rst_out_full: got %b expected 0", bus.out_out_full); else passed++;
      total++; if ({bus.out_overflow, bus.out_underflow} !== 2'b00) $display("FAIL rst_flags: got %b expected 00", {bus.out_overflow, bus.out_underflow}); else passed++;
      total++; if (bus.out_inport_data !== 32'h0) $display("FAIL rst_inport_data: got %h expected 0", bus.out_inport_data); else passed++;
   endtask

   task automatic test_overflow();
      logic [31:0] words [4];
      words = '{32'h11, 32'h22, 32'h33, 32'h44};
      bus.host_tx_ready = 1'b0;
      bus.in_outport_write = 1'b1;
      bus.in_outport_data = 32'h11;
      tick();
      total++; if (bus.host_tx_valid !== 1'b1) $display("FAIL ovf_valid_latency: got %b expected 1", bus.host_tx_valid); else passed++;
      for (int i = 1; i < 4; i++) begin
         bus.in_outport_data = words[i];
         tick();
      end
      total++; if (bus.out_out_full !== 1'b1) $display("FAIL ovf_full: got %b expected 1", bus.out_out_full); else passed++;
      total++; if (bus.out_overflow !== 1'b0) $display("FAIL ovf_early: got %b expected 0", bus.out_overflow); else passed++;
      bus.in_outport_data = 32'h55;
      tick();
      bus.in_outport_write = 1'b0;
      total++; if (bus.out_overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", bus.out_overflow); else passed++;
      total++; if (bus.out_outport !== 32'h55) $display("FAIL ovf_outport: got %h expected 00000055", bus.out_outport); else passed++;
      total++; if (bus.out_out_full !== 1'b1) $display("FAIL ovf_still_full: got %b expected 1", bus.out_out_full); else passed++;
      bus.host_tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (bus.host_tx_valid !== 1'b1 || bus.host_tx_data !== words[i])
            $display("FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.host_tx_valid, bus.host_tx_data, words[i]);
         else passed++;
         tick();
      end
      total++; if (bus.host_tx_valid !== 1'b0) $display("FAIL drain_empty: got %b expected 0", bus.host_tx_valid); else passed++;
      bus.host_tx_ready = 1'b0;
      bus.in_clear_flags = 1'b1;
      tick();
      bus.in_clear_flags = 1'b0;
      total++; if (bus.out_overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", bus.out_overflow); else passed++;
   endtask

   task automatic test_full_with_pop();
      logic [31:0] exp [4];
      exp = '{32'h02, 32'h03, 32'h04, 32'hAA};
      bus.host_tx_ready = 1'b0;
      bus.in_outport_write = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         bus.in_outport_data = 32'(i);
         tick();
      end
      bus.host_tx_ready = 1'b1;
      bus.in_outport_data = 32'hAA;
      tick();
      bus.in_outport_write = 1'b0;
      total++; if (bus.out_overflow !== 1'b0) $display("FAIL fwp_no_overflow: got %b expected 0", bus.out_overflow); else passed++;
      total++; if (bus.out_out_full !== 1'b1) $display("FAIL fwp_full: got %b expected 1", bus.out_out_full); else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (bus.host_tx_data !== exp[i])
            $display("FAIL fwp_order_%0d: got %h expected %h", i, bus.host_tx_data, exp[i]);
         else passed++;
         tick();
      end
      total++; if (bus.host_tx_valid !== 1'b0) $display("FAIL fwp_empty: got %b expected 0", bus.host_tx_valid); else passed++;
      bus.host_tx_ready = 1'b0;
   endtask

   task automatic test_host_rx();
      bus.host_rx_valid = 1'b1;
      bus.host_rx_data  = 32'hDEADBEEF;
      tick();
      chk("rx_first_head", bus.out_inport_data, 32'hDEADBEEF);
      total++; if (bus.out_in_empty !== 1'b0) $display("FAIL rx_not_empty: got %b expected 0", bus.out_in_empty); else passed++;
      bus.host_rx_data = 32'h12345678;
      tick();
      bus.host_rx_valid = 1'b0;
      chk("rx_head_kept", bus.out_inport_data, 32'hDEADBEEF);
      bus.in_inport_read = 1'b1;
      tick();
      chk("rx_after_read1", bus.out_inport_data, 32'h12345678);
      tick();
      total++; if (bus.out_in_empty !== 1'b1) $display("FAIL rx_empty_after_read2: got %b expected 1", bus.out_in_empty); else passed++;
      chk("rx_data_zero", bus.out_inport_data, 32'h0);
      total++; if (bus.out_underflow !== 1'b0) $display("FAIL rx_udf_early: got %b expected 0", bus.out_underflow); else passed++;
      tick();
      bus.in_inport_read = 1'b0;
      total++; if (bus.out_underflow !== 1'b1) $display("FAIL rx_underflow: got %b expected 1", bus.out_underflow); else passed++;
      chk("rx_udf_data_zero", bus.out_inport_data, 32'h0);
      total++; if (bus.out_in_empty !== 1'b1) $display("FAIL rx_udf_empty: got %b expected 1", bus.out_in_empty); else passed++;
   endtask

   task automatic test_clear_priority();
      bus.in_inport_read = 1'b1;
      bus.in_clear_flags = 1'b1;
      tick();
      bus.in_inport_read = 1'b0;
      bus.in_clear_flags = 1'b0;
      total++; if (bus.out_underflow !== 1'b0) $display("FAIL clear_priority: got %b expected 0", bus.out_underflow); else passed++;
   endtask

   task automatic test_back_to_back();
      bus.host_rx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.host_rx_data = 32'hB0 + 32'(i);
         tick();
      end
      total++; if (bus.host_rx_ready !== 1'b0) $display("FAIL b2b_ready_low: got %b expected 0", bus.host_rx_ready); else passed++;
      bus.host_rx_data = 32'hFF;
      tick();
      chk("b2b_head_full", bus.out_inport_data, 32'hB0);
      bus.host_rx_valid = 1'b0;
      bus.in_inport_read = 1'b1;
      tick();
      chk("b2b_pop1", bus.out_inport_data, 32'hB1);
      total++; if (bus.host_rx_ready !== 1'b1) $display("FAIL b2b_ready_back: got %b expected 1", bus.host_rx_ready); else passed++;
      bus.host_rx_valid = 1'b1;
      bus.host_rx_data = 32'hC0;
      tick();
      bus.host_rx_valid = 1'b0;
      chk("b2b_push_pop", bus.out_inport_data, 32'hB2);
      total++; if (bus.host_rx_ready !== 1'b1) $display("FAIL b2b_count_same: got %b expected 1", bus.host_rx_ready); else passed++;
      tick();
      chk("b2b_pop3", bus.out_inport_data, 32'hB3);
      tick();
      chk("b2b_pop4", bus.out_inport_data, 32'hC0);
      bus.in_inport_read = 1'b0;
   endtask

   task automatic test_async_reset();
      bus.host_rx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.host_rx_data = 32'hD0 + 32'(i);
         tick();
      end
      bus.host_rx_valid = 1'b0;
      bus.in_outport_write = 1'b1;
      bus.in_outport_data = 32'h77;
      tick();
      bus.in_outport_write = 1'b0;
      total++; if (bus.host_rx_ready !== 1'b0) $display("FAIL ar_filled: got %b expected 0", bus.host_rx_ready); else passed++;
      #2 reset = 1'b0;
      #1;
      total++; if (bus.out_in_empty !== 1'b1) $display("FAIL ar_in_empty: got %b expected 1", bus.out_in_empty); else passed++;
      total++; if (bus.host_rx_ready !== 1'b1) $display("FAIL ar_rx_ready: got %b expected 1", bus.host_rx_ready); else passed++;
      total++; if (bus.host_tx_valid !== 1'b0) $display("FAIL ar_tx_valid: got %b expected 0", bus.host_tx_valid); else passed++;
      chk("ar_outport", bus.out_outport, 32'h0);
      tick();
      reset = 1'b1;
      tick();
      total++; if (bus.out_in_empty !== 1'b1) $display("FAIL ar_after_release: got %b expected 1", bus.out_in_empty); else passed++;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      test_reset();
      test_overflow();
      test_full_with_pop();
      test_host_rx();
      test_clear_priority();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/io_port_controller.md
# io_port_controller

Buffered I/O peripheral for the Mini-SRC processor, sitting on the far side of the processor's in-port/out-port interface. Words the processor writes to the out-port are queued for an external host over a valid/ready stream. Words the host sends are queued and presented to the processor's in-port, one word per in-port read. It replaces the bare out-port register and raw in-port pins with two FIFOs, status flags and sticky error bits.

## Interface
Parameters:
- DATA_WIDTH, 32: word width on both directions.
- DEPTH, 4: entries per FIFO; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; one clock.
- in_outport_write  input  1  processor out-port write strobe, one cycle.
- in_outport_data  input  DATA_WIDTH  word on the processor bus during the write strobe.
- in_inport_read  input  1  processor in-port read strobe; pops the in-FIFO.
- out_inport_data  output  DATA_WIDTH  head of the in-FIFO; 0 when empty.
- out_outport  output  DATA_WIDTH  last word written by the processor (display mirror).
- out_in_empty  output  1  in-FIFO empty.
- out_out_full  output  1  out-FIFO full.
- out_overflow  output  1  sticky: a processor write was dropped.
- out_underflow  output  1  sticky: a processor read hit an empty in-FIFO.
- in_clear_flags  input  1  clears both sticky flags.
- host_tx_valid / host_tx_ready / host_tx_data  output / input / DATA_WIDTH output  out-FIFO stream to the host.
- host_rx_valid / host_rx_ready / host_rx_data  input / output / DATA_WIDTH input  host stream into the in-FIFO.

## Operation
- Out path: on in_outport_write, push in_outport_data and load out_outport.
  - When the out-FIFO is full, the push is accepted only if host_tx_valid and host_tx_ready are both high in the same cycle (the pop frees a slot).
  - Otherwise the word is dropped and out_overflow is set. out_outport updates regardless.
- Host tx: host_tx_valid = out-FIFO not empty. host_tx_data = out-FIFO head. The head is popped when valid and ready are both high.
- In path: host_rx_ready = in-FIFO not full, derived from the registered count only. A word is pushed when host_rx_valid and host_rx_ready are both high.
- Processor read: out_inport_data shows the in-FIFO head (show-ahead).
  - in_inport_read pops the head when the in-FIFO is not empty.
  - When empty, the read has no effect on FIFO state and sets out_underflow; the data reads as 0.
- Counts are $clog2(DEPTH)+1 bits wide. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, both pointers advance.
- in_clear_flags takes priority over a set in the same cycle: both flags are 0 after that edge.
- Reset values: all pointers and counts 0; out_outport 0; flags 0; out_in_empty 1; out_out_full 0; host_tx_valid 0; host_rx_ready 1; out_inport_data 0.
- Reset mid-operation discards all queued words immediately (asynchronous). Host handshakes in flight are lost; the host must resend.

## Timing
- All state updates on the rising edge of clk.
- Processor write at edge N: host_tx_valid high after edge N, so the host can pop at edge N+1. Minimum latency is 1 cycle.
- Host rx push at edge N: word on out_inport_data and out_in_empty low after edge N. The processor may read at edge N+1.
- Status outputs (empty, full, flags, ready, valid) are registered-state decodes with no combinational path from input strobes.
- out_inport_data and host_tx_data are combinational from FIFO RAM and read pointer only.
- Throughput: one word per cycle per direction, sustained.

## Structure
- Shared constants header io_defs: default DATA_WIDTH and DEPTH.
- One sub-module, sync_fifo, instantiated twice.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, wdata, rdata (show-ahead), empty, full, count.
  - Reset: asynchronous, active-low.
- The top level adds overflow/underflow logic, the out_outport register and the full-with-pop acceptance rule.

## Test plan
- Reset, then idle: out_in_empty=1, host_rx_ready=1, host_tx_valid=0, out_outport=0.
- Processor writes 0x11, 0x22, 0x33, 0x44 with host_tx_ready=0, then a fifth write of 0x55:
  - out_out_full=1, out_overflow=1, out_outport=0x55.
  - Then host_tx_ready=1 drains 0x11, 0x22, 0x33, 0x44 in order on consecutive cycles.
- Out-FIFO full with host_tx_ready=1, processor writes 0xAA in the same cycle: no overflow. 0xAA is delivered 4th after the current head.
- Host sends 0xDEADBEEF, then 0x12345678:
  - out_inport_data=0xDEADBEEF the cycle after the first handshake.
  - An in_inport_read pops it, leaving 0x12345678.
  - A second read leaves out_in_empty=1.
  - A third read sets out_underflow=1 and out_inport_data stays 0.
- in_clear_flags asserted in the same cycle as an empty read: out_underflow=0 after the edge.
- Host fills the in-FIFO, then reset is pulsed low mid-cycle: out_in_empty=1 and host_rx_ready=1 asynchronously, before the next edge.
